// File: rtl/tie_queue_param.sv
// Parameterised show-ahead FIFO for TIE queue ports: registered count drives all status
// outputs, with sticky overflow/underflow flags and a synchronous flush.
module tie_queue_param #(
  parameter int unsigned BITWIDTH  = 16,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PTRW      = 6,
  parameter int unsigned AFULL_TH  = 56,
  parameter int unsigned AEMPTY_TH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TIE_FIFO_OUT_PushReq,
  input  logic [BITWIDTH-1:0] TIE_FIFO_OUT,
  output logic                TIE_FIFO_OUT_Full,
  input  logic                TIE_FIFO_IN_PopReq,
  output logic [BITWIDTH-1:0] TIE_FIFO_IN,
  output logic                TIE_FIFO_IN_Empty,
  input  logic                Flush,
  output logic [PTRW:0]       Level,
  output logic                AlmostFull,
  output logic                AlmostEmpty,
  output logic                Overflow,
  output logic                Underflow
);

  localparam logic [PTRW:0]   DepthCnt   = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   AfullCnt   = (PTRW+1)'(AFULL_TH);
  localparam logic [PTRW:0]   AemptyCnt  = (PTRW+1)'(AEMPTY_TH);
  localparam logic [PTRW:0]   CntOne     = (PTRW+1)'(1);
  localparam logic [PTRW-1:0] PtrOne     = PTRW'(1);

  logic [BITWIDTH-1:0] store_q [DEPTH];
  logic [PTRW-1:0]     wp_q, wp_d;
  logic [PTRW-1:0]     rp_q, rp_d;
  logic [PTRW:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic full, empty;
  logic pop_acc, push_acc;
  logic do_write;

  // Status is decoded from the registered count only, so a push never bypasses.
  assign full        = (count_q == DepthCnt);
  assign empty       = (count_q == '0);
  assign Level       = count_q;
  assign AlmostFull  = (count_q >= AfullCnt);
  assign AlmostEmpty = (count_q <= AemptyCnt);

  assign TIE_FIFO_OUT_Full = full;
  assign TIE_FIFO_IN_Empty = empty;
  assign TIE_FIFO_IN       = store_q[rp_q];
  assign Overflow          = ovf_q;
  assign Underflow         = unf_q;

  // A push into a full queue is allowed when a pop frees the slot in the same cycle.
  assign pop_acc  = TIE_FIFO_IN_PopReq && !empty;
  assign push_acc = TIE_FIFO_OUT_PushReq && (!full || pop_acc);

  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    do_write = 1'b0;
    if (Flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push_acc) begin
        wp_d     = wp_q + PtrOne;
        do_write = 1'b1;
      end
      if (pop_acc) begin
        rp_d = rp_q + PtrOne;
      end
      if (push_acc && !pop_acc) begin
        count_d = count_q + CntOne;
      end else if (pop_acc && !push_acc) begin
        count_d = count_q - CntOne;
      end
      if (TIE_FIFO_OUT_PushReq && !push_acc) begin
        ovf_d = 1'b1;
      end
      if (TIE_FIFO_IN_PopReq && empty) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is never cleared; reset and flush only move the pointers.
  always_ff @(posedge CLK) begin
    if (!RST && do_write) begin
      store_q[wp_q] <= TIE_FIFO_OUT;
    end
  end

endmodule

// File: tb/tb_tie_queue_param.sv
// Directed self-checking bench for tie_queue_param at default parameters.
module tb_tie_queue_param;

  logic        CLK = 1'b0;
  logic        RST;
  logic        TIE_FIFO_OUT_PushReq;
  logic [15:0] TIE_FIFO_OUT;
  logic        TIE_FIFO_OUT_Full;
  logic        TIE_FIFO_IN_PopReq;
  logic [15:0] TIE_FIFO_IN;
  logic        TIE_FIFO_IN_Empty;
  logic        Flush;
  logic [6:0]  Level;
  logic        AlmostFull;
  logic        AlmostEmpty;
  logic        Overflow;
  logic        Underflow;

  int errors = 0;
  int checks = 0;

  tie_queue_param dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .TIE_FIFO_OUT_PushReq (TIE_FIFO_OUT_PushReq),
    .TIE_FIFO_OUT         (TIE_FIFO_OUT),
    .TIE_FIFO_OUT_Full    (TIE_FIFO_OUT_Full),
    .TIE_FIFO_IN_PopReq   (TIE_FIFO_IN_PopReq),
    .TIE_FIFO_IN          (TIE_FIFO_IN),
    .TIE_FIFO_IN_Empty    (TIE_FIFO_IN_Empty),
    .Flush                (Flush),
    .Level                (Level),
    .AlmostFull           (AlmostFull),
    .AlmostEmpty          (AlmostEmpty),
    .Overflow             (Overflow),
    .Underflow            (Underflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    TIE_FIFO_OUT_PushReq = 1'b1;
    TIE_FIFO_OUT         = d;
    step();
    TIE_FIFO_OUT_PushReq = 1'b0;
  endtask

  task automatic pop_word();
    TIE_FIFO_IN_PopReq = 1'b1;
    step();
    TIE_FIFO_IN_PopReq = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST                  = 1'b0;
    TIE_FIFO_OUT_PushReq = 1'b0;
    TIE_FIFO_OUT         = '0;
    TIE_FIFO_IN_PopReq   = 1'b0;
    Flush                = 1'b0;
    #2;
    do_reset();

    check("rst_empty", 32'(TIE_FIFO_IN_Empty), 1);
    check("rst_full", 32'(TIE_FIFO_OUT_Full), 0);
    check("rst_level", 32'(Level), 0);
    check("rst_aempty", 32'(AlmostEmpty), 1);
    check("rst_afull", 32'(AlmostFull), 0);
    check("rst_ovf", 32'(Overflow), 0);
    check("rst_unf", 32'(Underflow), 0);

    // Pop on empty sets sticky underflow, nothing else moves.
    pop_word();
    check("unf_set", 32'(Underflow), 1);
    check("unf_level", 32'(Level), 0);
    check("unf_empty", 32'(TIE_FIFO_IN_Empty), 1);

    // No bypass: Empty stays set until the push edge.
    TIE_FIFO_OUT_PushReq = 1'b1;
    TIE_FIFO_OUT         = 16'h0001;
    #1;
    check("nobypass_empty", 32'(TIE_FIFO_IN_Empty), 1);
    step();
    TIE_FIFO_OUT_PushReq = 1'b0;
    check("push1_empty", 32'(TIE_FIFO_IN_Empty), 0);
    check("push1_head", 32'(TIE_FIFO_IN), 32'h0001);
    push_word(16'h0002);
    push_word(16'h0003);
    check("push3_level", 32'(Level), 3);
    check("push3_head", 32'(TIE_FIFO_IN), 32'h0001);
    pop_word();
    check("pop1_head", 32'(TIE_FIFO_IN), 32'h0002);
    pop_word();
    check("pop2_head", 32'(TIE_FIFO_IN), 32'h0003);
    check("pop2_level", 32'(Level), 1);
    pop_word();
    check("pop3_empty", 32'(TIE_FIFO_IN_Empty), 1);
    check("pop3_level", 32'(Level), 0);
    check("unf_sticky_push", 32'(Underflow), 1);

    // Flush at level 10 with a same-cycle push.
    for (int i = 0; i < 10; i++) push_word(16'(16'h0100 + i));
    check("pre_flush_level", 32'(Level), 10);
    Flush                = 1'b1;
    TIE_FIFO_OUT_PushReq = 1'b1;
    TIE_FIFO_OUT         = 16'h0FFF;
    step();
    Flush                = 1'b0;
    TIE_FIFO_OUT_PushReq = 1'b0;
    check("flush_level", 32'(Level), 0);
    check("flush_empty", 32'(TIE_FIFO_IN_Empty), 1);
    check("unf_sticky_flush", 32'(Underflow), 1);
    do_reset();
    check("unf_cleared", 32'(Underflow), 0);

    // Fill to full; AlmostFull boundary at 56.
    for (int i = 0; i < 64; i++) begin
      push_word(16'(16'h1000 + i));
      if (i == 54) check("afull_55", 32'(AlmostFull), 0);
      if (i == 55) check("afull_56", 32'(AlmostFull), 1);
    end
    check("full_flag", 32'(TIE_FIFO_OUT_Full), 1);
    check("full_level", 32'(Level), 64);
    check("full_ovf_clear", 32'(Overflow), 0);
    push_word(16'hDEAD);
    check("ovf_set", 32'(Overflow), 1);
    check("ovf_level", 32'(Level), 64);
    check("ovf_head", 32'(TIE_FIFO_IN), 32'h1000);

    // Simultaneous push/pop while full.
    do_reset();
    check("ovf_cleared", 32'(Overflow), 0);
    for (int i = 0; i < 64; i++) push_word(16'(16'h1000 + i));
    TIE_FIFO_OUT_PushReq = 1'b1;
    TIE_FIFO_IN_PopReq   = 1'b1;
    TIE_FIFO_OUT         = 16'hBEEF;
    step();
    TIE_FIFO_OUT_PushReq = 1'b0;
    TIE_FIFO_IN_PopReq   = 1'b0;
    check("pp_level", 32'(Level), 64);
    check("pp_full", 32'(TIE_FIFO_OUT_Full), 1);
    check("pp_ovf", 32'(Overflow), 0);
    check("pp_head", 32'(TIE_FIFO_IN), 32'h1001);
    for (int k = 0; k < 63; k++) begin
      check("pp_drain", 32'(TIE_FIFO_IN), 32'(16'h1001 + k));
      pop_word();
    end
    check("pp_beef", 32'(TIE_FIFO_IN), 32'hBEEF);
    pop_word();
    check("pp_drain_empty", 32'(TIE_FIFO_IN_Empty), 1);

    // 70 words through the wrap; AlmostEmpty boundary at 8.
    for (int i = 0; i < 9; i++) push_word(16'(16'h2000 + i));
    check("ae_level9", 32'(Level), 9);
    check("ae_9", 32'(AlmostEmpty), 0);
    check("wrap_head0", 32'(TIE_FIFO_IN), 32'h2000);
    pop_word();
    check("ae_level8", 32'(Level), 8);
    check("ae_8", 32'(AlmostEmpty), 1);
    for (int i = 9; i < 70; i++) begin
      check("wrap_head", 32'(TIE_FIFO_IN), 32'(16'h2000 + i - 8));
      TIE_FIFO_OUT_PushReq = 1'b1;
      TIE_FIFO_IN_PopReq   = 1'b1;
      TIE_FIFO_OUT         = 16'(16'h2000 + i);
      step();
    end
    TIE_FIFO_OUT_PushReq = 1'b0;
    TIE_FIFO_IN_PopReq   = 1'b0;
    check("wrap_level", 32'(Level), 8);
    for (int i = 62; i < 70; i++) begin
      check("wrap_tail", 32'(TIE_FIFO_IN), 32'(16'h2000 + i));
      pop_word();
    end
    check("wrap_empty", 32'(TIE_FIFO_IN_Empty), 1);
    check("wrap_unf", 32'(Underflow), 0);

    // Reset at level 5 with a pop pending.
    for (int i = 0; i < 5; i++) push_word(16'(16'h3000 + i));
    check("pre_rst_level", 32'(Level), 5);
    RST                = 1'b1;
    TIE_FIFO_IN_PopReq = 1'b1;
    step();
    RST                = 1'b0;
    TIE_FIFO_IN_PopReq = 1'b0;
    check("midrst_level", 32'(Level), 0);
    check("midrst_empty", 32'(TIE_FIFO_IN_Empty), 1);
    check("midrst_unf", 32'(Underflow), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tie_queue_param.md
TIE_QUEUE_PARAM -- requirements
Module: tie_queue_param

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 16, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 64, number of entries (power of two, >=2).
REQ-003 The block SHALL have parameter PTRW, default 6, pointer width, equal to log2(DEPTH).
REQ-004 The block SHALL have parameter AFULL_TH, default 56, level at or above which AlmostFull asserts (1..DEPTH).
REQ-005 The block SHALL have parameter AEMPTY_TH, default 8, level at or below which AlmostEmpty asserts (0..DEPTH-1).
REQ-006 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-008 The block SHALL have port TIE_FIFO_OUT_PushReq, input, 1, write request.
REQ-009 The block SHALL have port TIE_FIFO_OUT, input, BITWIDTH, write data.
REQ-010 The block SHALL have port TIE_FIFO_OUT_Full, output, 1, queue holds DEPTH entries.
REQ-011 The block SHALL have port TIE_FIFO_IN_PopReq, input, 1, read request.
REQ-012 The block SHALL have port TIE_FIFO_IN, output, BITWIDTH, head-of-queue data (show-ahead).
REQ-013 The block SHALL have port TIE_FIFO_IN_Empty, output, 1, queue holds 0 entries.
REQ-014 The block SHALL have port Flush, input, 1, synchronous discard of all entries.
REQ-015 The block SHALL have port Level, output, PTRW+1, current entry count 0..DEPTH.
REQ-016 The block SHALL have port AlmostFull, output, 1, Level >= AFULL_TH.
REQ-017 The block SHALL have port AlmostEmpty, output, 1, Level <= AEMPTY_TH.
REQ-018 The block SHALL have port Overflow, output, 1, sticky: a push was rejected.
REQ-019 The block SHALL have port Underflow, output, 1, sticky: a pop was rejected.

Function
REQ-020 State SHALL be write pointer wp, read pointer rp (PTRW bits, wrap DEPTH-1 -> 0), registered count (PTRW+1 bits), and DEPTH x BITWIDTH storage.
REQ-021 Full, Empty, Level, AlmostFull and AlmostEmpty SHALL be combinational decodes of the registered count only (Full = count==DEPTH, Empty = count==0).
REQ-022 TIE_FIFO_IN SHALL equal store[rp] combinationally; its value while Empty is don't-care.
REQ-023 A pop SHALL be accepted when PopReq=1 and Empty=0; it advances rp by one.
REQ-024 A push SHALL be accepted when PushReq=1 and (Full=0 or a pop is accepted in the same cycle); it writes store[wp] and advances wp by one.
REQ-025 A push with PushReq=1 on an empty queue SHALL NOT bypass to TIE_FIFO_IN in the same cycle; the word appears on TIE_FIFO_IN and Empty deasserts the cycle after the push edge (latency 1).
REQ-026 Count SHALL update as +1 (push only), -1 (pop only), unchanged (both or neither).
REQ-027 Simultaneous accepted push and pop when full SHALL leave count at DEPTH and Full=1; when count=1 pop-only SHALL give Empty=1 next cycle.
REQ-028 Overflow SHALL set on any cycle with PushReq=1 and push not accepted, and hold until RST.
REQ-029 Underflow SHALL set on any cycle with PopReq=1 and Empty=1, and hold until RST.
REQ-030 Flush=1 SHALL, at the edge, set wp=rp=count=0, discard any same-cycle push/pop, and leave Overflow/Underflow unchanged.
REQ-031 Priority SHALL be RST > Flush > push/pop.
REQ-032 Storage contents SHALL not be reset or cleared by Flush.

Reset
REQ-033 With RST=1 at an edge: wp=0, rp=0, count=0, Overflow=0, Underflow=0; hence Empty=1, Full=0, Level=0, AlmostEmpty=1, AlmostFull=0, from the following cycle.
REQ-034 RST asserted mid-operation SHALL discard all entries and ignore same-cycle PushReq/PopReq, without setting the sticky flags.

Verification
REQ-035 Reset, push 0x0001..0x0003 on 3 cycles, then pop 3 -> TIE_FIFO_IN reads 0x0001,0x0002,0x0003 in order; Empty=1 after third pop; Level 3 -> 0.
REQ-036 Push 64 words (defaults) -> Full=1, Level=64, AlmostFull from Level 56; 65th push rejected -> Overflow=1, contents unchanged.
REQ-037 At Full, PushReq=PopReq=1 with 0xBEEF -> Level stays 64, head advances, 0xBEEF read out 64 pops later; Overflow stays 0.
REQ-038 Pop on empty after reset -> Underflow=1, Level=0, rp unchanged; persists through subsequent pushes and a Flush, cleared only by RST.
REQ-039 Push 70 / pop 70 interleaved across pointer wrap -> data order preserved; Level 9 -> AlmostEmpty=0, Level 8 -> AlmostEmpty=1.
REQ-040 Level 10, assert Flush with PushReq=1 -> Level=0, Empty=1 next cycle; assert RST with Level 5 and PopReq=1 -> Level=0, Underflow=0.
